// File: rtl/div_chk_pkg.sv
// rtl/div_chk_pkg.sv - shared defaults, FSM state type and iteration bound for the divider checker
package div_chk_pkg;
  localparam int DEF_QW = 8;
  localparam int DEF_DW = 8;
  localparam int DEF_NW = 16;
  localparam int DEF_CW = 16;
  localparam int ITER_LAST = DEF_QW - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/div_reconstruct_checker.sv
// rtl/div_reconstruct_checker.sv - rebuilds q*d+r by shift-add, reports error against n, counts mismatches
module div_reconstruct_checker
  import div_chk_pkg::*;
#(
  parameter int QW = DEF_QW,
  parameter int DW = DEF_DW,
  parameter int NW = DEF_NW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] d,
  input  logic [QW-1:0] q,
  input  logic [DW-1:0] r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] n_rec,
  output logic [NW:0]   err,
  output logic          mismatch,
  input  logic          clr_stats,
  output logic [CW-1:0] sample_cnt,
  output logic [CW-1:0] mismatch_cnt
);
  localparam int IW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [IW-1:0] ITER_END = IW'(QW - 1);

  state_t        state_q, state_d;
  logic [NW-1:0] acc_q, acc_d, mcand_q, mcand_d, n_lat_q, n_lat_d, n_rec_q, n_rec_d;
  logic [QW-1:0] mplier_q, mplier_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [NW:0]   err_q, err_d;
  logic          mismatch_q, mismatch_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [NW-1:0] acc_step;
  logic [NW:0]   err_step;
  logic          res_hs;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign err_step = {1'b0, acc_step} - {1'b0, n_lat_q};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    iter_d     = iter_q;
    n_lat_d    = n_lat_q;
    n_rec_d    = n_rec_q;
    err_d      = err_q;
    mismatch_d = mismatch_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          n_lat_d  = n;
          acc_d    = NW'(r);
          mcand_d  = NW'(d);
          mplier_d = q;
          iter_d   = '0;
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + IW'(1);
        // Result registers are loaded on the final add so DONE presents them immediately.
        if (iter_q == ITER_END) begin
          state_d    = ST_DONE;
          n_rec_d    = acc_step;
          err_d      = err_step;
          mismatch_d = |err_step;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      iter_q      <= '0;
      n_lat_q     <= '0;
      n_rec_q     <= '0;
      err_q       <= '0;
      mismatch_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      iter_q      <= iter_d;
      n_lat_q     <= n_lat_d;
      n_rec_q     <= n_rec_d;
      err_q       <= err_d;
      mismatch_q  <= mismatch_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign res_hs = out_valid_q && out_ready;

  sat_counter #(.W(CW)) u_sample_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_stats),
    .inc  (res_hs),
    .cnt  (sample_cnt)
  );

  sat_counter #(.W(CW)) u_mismatch_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_stats),
    .inc  (res_hs && mismatch_q),
    .cnt  (mismatch_cnt)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign n_rec     = n_rec_q;
  assign err       = err_q;
  assign mismatch  = mismatch_q;
endmodule

// File: tb/tb_div_reconstruct_checker.sv
// tb/tb_div_reconstruct_checker.sv - randomized self-checking bench for div_reconstruct_checker
module tb_div_reconstruct_checker;
  localparam int QW = 8;
  localparam int DW = 8;
  localparam int NW = 16;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NW-1:0] n = '0;
  logic [DW-1:0] d = '0;
  logic [QW-1:0] q = '0;
  logic [DW-1:0] r = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NW-1:0] n_rec;
  logic [NW:0]   err;
  logic          mismatch;
  logic          clr_stats = 1'b0;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] mismatch_cnt;

  int errors = 0;
  int checks = 0;
  int m_samples = 0;
  int m_mis = 0;

  always #5 clk = ~clk;

  div_reconstruct_checker #(.QW(QW), .DW(DW), .NW(NW), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .n           (n),
    .d           (d),
    .q           (q),
    .r           (r),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .n_rec       (n_rec),
    .err         (err),
    .mismatch    (mismatch),
    .clr_stats   (clr_stats),
    .sample_cnt  (sample_cnt),
    .mismatch_cnt(mismatch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_sample_cnt"}, 32'(sample_cnt), 32'(m_samples));
    check({tag, "_mismatch_cnt"}, 32'(mismatch_cnt), 32'(m_mis));
  endtask

  // One full transaction; all timing is taken at negedges, inputs change at negedges.
  task automatic do_sample(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qq,
                           input logic [7:0] rr, input int hold, input bit clr_hs);
    int p;
    int k;
    logic [15:0] exp_rec;
    logic [16:0] exp_err;
    logic exp_mis;
    p = qq * dd + rr;
    exp_rec = p[15:0];
    exp_err = {1'b0, exp_rec} - {1'b0, nn};
    exp_mis = (exp_rec != nn);

    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    n = nn; d = dd; q = qq; r = rr; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = $urandom; d = $urandom; q = $urandom; r = $urandom;
    check("in_ready_busy", 32'(in_ready), 32'd0);
    for (int i = 1; i < QW; i++) @(negedge clk);
    check("early_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("n_rec", 32'(n_rec), 32'(exp_rec));
    check("err", 32'(err), 32'(exp_err));
    check("mismatch", 32'(mismatch), 32'(exp_mis));

    for (int h = 0; h < hold; h++) begin
      in_valid = (h == 0);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_n_rec", 32'(n_rec), 32'(exp_rec));
      check("hold_err", 32'(err), 32'(exp_err));
      check("hold_ready", 32'(in_ready), 32'd0);
      check_counts("hold");
    end
    in_valid = 1'b0;

    out_ready = 1'b1;
    clr_stats = clr_hs;
    @(negedge clk);
    out_ready = 1'b0;
    clr_stats = 1'b0;
    if (clr_hs) begin
      m_samples = 0;
      m_mis = 0;
    end else begin
      if (m_samples < CNT_MAX) m_samples++;
      if (exp_mis && m_mis < CNT_MAX) m_mis++;
    end
    check_counts("post_hs");
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_ready", 32'(in_ready), 32'd1);
    check("post_hs_n_rec_hold", 32'(n_rec), 32'(exp_rec));
  endtask

  initial begin
    logic [15:0] nn;
    logic [7:0] dd, qq, rr;
    int p;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_n_rec", 32'(n_rec), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check_counts("rst");

    do_sample(16'd1000, 8'd7, 8'd142, 8'd6, 0, 1'b0);
    do_sample(16'd1000, 8'd7, 8'd143, 8'd6, 0, 1'b0);
    check("plus7_err", 32'(err), 32'h0_0007);
    do_sample(16'd1000, 8'd7, 8'd141, 8'd6, 0, 1'b0);
    check("minus7_err", 32'(err), 32'h1_FFF9);
    do_sample(16'd65280, 8'd255, 8'd255, 8'd255, 0, 1'b0);
    do_sample(16'd5, 8'd0, 8'd200, 8'd5, 0, 1'b0);
    do_sample(16'd1000, 8'd7, 8'd143, 8'd6, 5, 1'b0);

    // Abort a sample mid-multiply with reset.
    n = 16'd1000; d = 8'd7; q = 8'd142; r = 8'd6; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_samples = 0;
    m_mis = 0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check_counts("midrst");
    do_sample(16'd50, 8'd5, 8'd10, 8'd0, 0, 1'b0);

    do_sample(16'd1, 8'd3, 8'd3, 8'd3, 0, 1'b0);
    do_sample(16'd2, 8'd9, 8'd9, 8'd9, 1, 1'b1);
    check("clr_sample_zero", 32'(sample_cnt), 32'd0);
    check("clr_mis_zero", 32'(mismatch_cnt), 32'd0);

    for (int i = 0; i < 40; i++) begin
      qq = 8'($urandom); dd = 8'($urandom); rr = 8'($urandom);
      p = qq * dd + rr;
      nn = ($urandom_range(0, 1) == 1) ? p[15:0] : 16'($urandom);
      do_sample(nn, dd, qq, rr, int'($urandom_range(0, 2)), 1'b0);
    end

    for (int i = 0; i < CNT_MAX + 5; i++) begin
      qq = 8'($urandom); dd = 8'($urandom); rr = 8'($urandom);
      p = qq * dd + rr;
      nn = p[15:0] ^ 16'h0001;
      do_sample(nn, dd, qq, rr, 0, 1'b0);
    end
    check("sat_mismatch_cnt", 32'(mismatch_cnt), 32'(CNT_MAX));
    check("sat_sample_cnt", 32'(sample_cnt), 32'(CNT_MAX));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_reconstruct_checker.md
Name: div_reconstruct_checker

Overview:
- Sequential shift-add multiply-accumulate unit that inverts the array divider's operation: from (q, d, r) it rebuilds n_rec = q*d + r.
- Compares n_rec against the original dividend n and reports the signed error per sample.
- Keeps saturating sample and mismatch counters.
- Sits beside exact and approximate divider instances in power/MSE evaluation benches and error-monitor wrappers.

Parameters:
- QW, 8: quotient width; also the number of multiply iterations.
- DW, 8: divisor and remainder width.
- NW, 16: dividend width; n_rec width.
- CW, 16: statistics counter width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- n  in  NW  original dividend.
- d  in  DW  divisor.
- q  in  QW  quotient under test.
- r  in  DW  remainder under test.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- n_rec  out  NW  reconstructed dividend q*d+r.
- err  out  NW+1  signed n_rec - n, two's complement.
- mismatch  out  1  err != 0.
- clr_stats  in  1  synchronous clear of both counters.
- sample_cnt  out  CW  completed result handshakes, saturating.
- mismatch_cnt  out  CW  completed handshakes with mismatch=1, saturating.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - in_ready=1 after reset release; out_valid=0.
  - n_rec, err, mismatch, sample_cnt and mismatch_cnt all clear to 0.
  - Reset mid-operation aborts the sample with no counter update.
- FSM states IDLE, MUL, DONE:
  - IDLE: in_ready=1. On in_valid&in_ready, latch n and load the datapath:
    - acc = zero-extended r
    - mcand = zero-extended d (NW bits)
    - mplier = q
    - iter = 0
    - Go to MUL.
  - MUL: in_ready=0. Each cycle:
    - if mplier[0], acc += mcand (mod 2^NW)
    - mcand <<= 1; mplier >>= 1; iter++
    - After QW cycles (iter==QW-1 transition), go to DONE.
  - DONE: out_valid=1.
    - n_rec = acc; err = {1'b0,acc} - {1'b0,n_latched}; mismatch = |err.
    - Outputs stay stable while out_ready=0.
    - On out_ready, go to IDLE next cycle.
- Latency: input handshake at edge T; out_valid high from cycle T+QW+1. Throughput is one sample per QW+2 cycles minimum.
- No overlap: in_ready is 0 in MUL and DONE, so in_valid there is ignored.
- Width rule: for in-range values (q,d,r ≤ 2^DW-1 with NW=2*DW), max n_rec = 65280 fits NW bits. Overflow wraps mod 2^NW and is not flagged.
- d=0 gives n_rec=r.
- err range is -(2^NW-1) to +(2^NW-1).
- Counters:
  - On out_valid&out_ready: sample_cnt++; mismatch_cnt++ if mismatch.
  - Each counter saturates at 2^CW-1 and holds there.
  - clr_stats has priority over a same-cycle increment; the result is 0.
  - clr_stats does not affect the FSM.
- After leaving DONE, n_rec/err/mismatch hold their last values until the next DONE. Consumers must qualify them with out_valid.

Decomposition:
- Shared package div_chk_pkg holds:
  - QW/DW/NW/CW defaults
  - state enum (IDLE, MUL, DONE)
  - localparam ITER_LAST = QW-1
- One sub-module, sat_counter (width CW; inputs clk, rst_n, clr, inc; output cnt), instantiated twice for sample_cnt and mismatch_cnt.
- The shift-add datapath stays inline.

Test Plan:
- Exact sample: n=1000, d=7, q=142, r=6, in_valid at T → out_valid at T+9, n_rec=1000, err=0, mismatch=0; after out_ready, sample_cnt=1, mismatch_cnt=0.
- Approximate sample: n=1000, d=7, q=143, r=6 → n_rec=1007, err=+7, mismatch=1; mismatch_cnt increments. Also q=141, r=6 → n_rec=993, err=-7 (17'h1FFF9).
- Max operands: q=255, d=255, r=255, n=65280 → n_rec=65280, err=0. Also d=0, q=200, r=5, n=5 → n_rec=5.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, n_rec and err stable, in_ready=0, a pulsed in_valid is ignored, counters unchanged; release → one increment only.
- Reset mid-MUL: rst_n=0 at T+4 → next cycle in_ready=1, out_valid=0, counters 0. A new sample n=50, d=5, q=10, r=0 then gives n_rec=50 at the correct latency.
- Stats: clr_stats asserted in the same cycle as a result handshake → both counters read 0. Run 65537 mismatching samples → mismatch_cnt saturates at 16'hFFFF.
